// File: rtl/flex_enable_conv_if.sv
// Enable-conversion bus: slow-side inputs, flush/clear controls and fast-side outputs.
interface flex_enable_conv_if #(
  parameter int unsigned NUM_CH = 4
) ();
  logic [NUM_CH-1:0] slow_enable;
  logic              clr;
  logic              clr_ovf;
  logic [NUM_CH-1:0] fast_enable;
  logic [NUM_CH-1:0] pending_nz;
  logic [NUM_CH-1:0] overflow;

  modport master (
    output slow_enable, clr, clr_ovf,
    input  fast_enable, pending_nz, overflow
  );

  modport slave (
    input  slow_enable, clr, clr_ovf,
    output fast_enable, pending_nz, overflow
  );
endinterface

// File: rtl/flex_enable_conv.sv
// Per-channel slow-enable to fast one-cycle pulse converter with event queueing,
// minimum pulse spacing and sticky overflow reporting.
module flex_enable_conv #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0,
  parameter int unsigned MIN_GAP     = 0,
  parameter int unsigned PEND_DEPTH  = 7
) (
  input logic            clk,
  input logic            rst,
  flex_enable_conv_if.slave bus
);

  localparam int unsigned PEND_W = $clog2(PEND_DEPTH + 1);
  localparam int unsigned GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] edge_c;
  logic [NUM_CH-1:0] event_q;
  logic [NUM_CH-1:0] issue_c;
  logic [NUM_CH-1:0] ovf_set_c;
  logic [NUM_CH-1:0] fast_q;
  logic [NUM_CH-1:0] pnz_q;
  logic [NUM_CH-1:0] ovf_q;
  logic [PEND_W-1:0] pend_q [NUM_CH];
  logic [PEND_W-1:0] pend_d [NUM_CH];
  logic [GAP_W-1:0]  gap_q  [NUM_CH];
  logic [GAP_W-1:0]  gap_d  [NUM_CH];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_out = bus.slow_enable;
    end else begin : g_sync
      logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

      // Input synchronizer shift chain
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
          end
        end else begin
          sync_q[0] <= bus.slow_enable;
          for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
          end
        end
      end

      assign sync_out = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Edge detection against the previous sample in the selected direction
  always_comb begin
    edge_c = '0;
    case (EDGE_MODE)
      0:       edge_c = sync_out & ~prev_q;
      1:       edge_c = ~sync_out & prev_q;
      default: edge_c = sync_out ^ prev_q;
    endcase
  end

  // Issue decision plus pending and gap counter next-state per channel
  always_comb begin
    issue_c   = '0;
    ovf_set_c = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pend_d[ch] = pend_q[ch];
      gap_d[ch]  = gap_q[ch];
      if (bus.clr) begin
        pend_d[ch] = '0;
        gap_d[ch]  = '0;
      end else begin
        issue_c[ch] = (event_q[ch] || (pend_q[ch] != '0)) && (gap_q[ch] == '0);
        if (issue_c[ch]) begin
          gap_d[ch] = GAP_W'(MIN_GAP);
        end else if (gap_q[ch] != '0) begin
          gap_d[ch] = gap_q[ch] - GAP_W'(1);
        end
        if (event_q[ch] && !issue_c[ch]) begin
          if (pend_q[ch] == PEND_W'(PEND_DEPTH)) begin
            ovf_set_c[ch] = 1'b1;
          end else begin
            pend_d[ch] = pend_q[ch] + PEND_W'(1);
          end
        end else if (!event_q[ch] && issue_c[ch]) begin
          pend_d[ch] = pend_q[ch] - PEND_W'(1);
        end
      end
    end
  end

  // Channel state and registered outputs; a new overflow beats clr_ovf
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      event_q <= '0;
      fast_q  <= '0;
      pnz_q   <= '0;
      ovf_q   <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        pend_q[ch] <= '0;
        gap_q[ch]  <= '0;
      end
    end else begin
      prev_q  <= sync_out;
      event_q <= edge_c;
      fast_q  <= issue_c;
      ovf_q   <= ovf_set_c | (ovf_q & ~{NUM_CH{bus.clr_ovf}});
      for (int ch = 0; ch < NUM_CH; ch++) begin
        pend_q[ch] <= pend_d[ch];
        gap_q[ch]  <= gap_d[ch];
        pnz_q[ch]  <= (pend_d[ch] != '0);
      end
    end
  end

  assign bus.fast_enable = fast_q;
  assign bus.pending_nz  = pnz_q;
  assign bus.overflow    = ovf_q;

endmodule
